vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 11 +
 rtl/vend_controller_refund_counter.sv | 23 ++
 rtl/vend_controller.sv | 140 ++++++++++++++
 tb/tb_vend_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
package vend_pkg;
  localparam int unsigned CREDIT_W   = 4;
  localparam int unsigned MAX_CREDIT = 15;

  typedef enum logic [1:0] {
    ACCEPT   = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_e;
endpackage

// File: rtl/vend_controller_refund_counter.sv
// Refund down-counter: parallel load, saturating decrement, zero flag.
module refund_counter
  import vend_pkg::*;
(
  input  logic                clock,
  input  logic                reset_L,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                dec,
  output logic [CREDIT_W-1:0] count,
  output logic                zero
);
  logic [CREDIT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)                cnt_q <= '0;
    else if (load)               cnt_q <= load_val;
    else if (dec && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);
endmodule

// File: rtl/vend_controller.sv
// Coin-accepting vending FSM with registered pulse outputs.
// Define VEND_CANCEL_EN to enable cancel-driven refunds; otherwise cancel is ignored.
module vend_controller
  import vend_pkg::*;
(
  input  logic                clock,
  input  logic                reset_L,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                select,
  input  logic                cancel,
  input  logic [CREDIT_W-1:0] cost,
  input  logic                more,
  input  logic                exact,
  input  logic                less,
  output logic [CREDIT_W-1:0] paid,
  output logic                dispense,
  output logic                change_out,
  output logic                coin_reject,
  output logic                short_funds,
  output logic                busy
);
  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] paid_q, paid_d;
  logic                disp_q, disp_d, chg_q, chg_d, rej_q, rej_d, short_q, short_d, busy_q;
  logic                rc_load, rc_dec, rc_zero;
  logic [CREDIT_W-1:0] rc_load_val, rc_count;
  logic [CREDIT_W:0]   sum;
  logic                coin_ev, cancel_ev;

  refund_counter u_refund (
    .clock    (clock),
    .reset_L  (reset_L),
    .load     (rc_load),
    .load_val (rc_load_val),
    .dec      (rc_dec),
    .count    (rc_count),
    .zero     (rc_zero)
  );

  logic [CREDIT_W-1:0] unused_count;
  assign unused_count = rc_count;

  // A zero-valued coin is not an event at all, so it neither credits nor rejects.
  assign coin_ev = coin_valid && (coin_value != '0);
  assign sum     = {1'b0, paid_q} + {1'b0, coin_value};

`ifdef VEND_CANCEL_EN
  assign cancel_ev = cancel && (paid_q != '0);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_ev     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paid_d      = paid_q;
    disp_d      = 1'b0;
    chg_d       = 1'b0;
    rej_d       = 1'b0;
    short_d     = 1'b0;
    rc_load     = 1'b0;
    rc_load_val = '0;
    rc_dec      = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (cancel_ev) begin
          // First change pulse issues on this edge, so the counter holds the remainder.
          state_d     = CHANGE;
          paid_d      = '0;
          rc_load     = 1'b1;
          rc_load_val = paid_q - 1'b1;
          chg_d       = 1'b1;
          rej_d       = coin_ev;
        end else if (coin_ev) begin
          if (sum > (CREDIT_W+1)'(MAX_CREDIT)) rej_d  = 1'b1;
          else                                 paid_d = sum[CREDIT_W-1:0];
        end else if (select) begin
          if (less) begin
            short_d = 1'b1;
          end else if (exact || more) begin
            state_d     = DISPENSE;
            paid_d      = '0;
            rc_load     = 1'b1;
            rc_load_val = paid_q - cost;
            disp_d      = 1'b1;
          end
        end
      end
      DISPENSE: begin
        rej_d = coin_ev;
        if (!rc_zero) begin
          state_d = CHANGE;
          chg_d   = 1'b1;
          rc_dec  = 1'b1;
        end else begin
          state_d = ACCEPT;
        end
      end
      CHANGE: begin
        rej_d = coin_ev;
        if (!rc_zero) begin
          chg_d  = 1'b1;
          rc_dec = 1'b1;
        end else begin
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ACCEPT;
      paid_q  <= '0;
      disp_q  <= 1'b0;
      chg_q   <= 1'b0;
      rej_q   <= 1'b0;
      short_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      paid_q  <= paid_d;
      disp_q  <= disp_d;
      chg_q   <= chg_d;
      rej_q   <= rej_d;
      short_q <= short_d;
      busy_q  <= (state_d != ACCEPT);
    end
  end

  assign paid        = paid_q;
  assign dispense    = disp_q;
  assign change_out  = chg_q;
  assign coin_reject = rej_q;
  assign short_funds = short_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller; the comparator lives here as in the parent.
module tb_vend_controller;
  logic       clock, reset_L;
  logic       coin_valid, select, cancel;
  logic [3:0] coin_value, cost, paid;
  logic       more, exact, less;
  logic       dispense, change_out, coin_reject, short_funds, busy;
  int         checks, errors;

  vend_controller dut (
    .clock(clock), .reset_L(reset_L), .coin_valid(coin_valid), .coin_value(coin_value),
    .select(select), .cancel(cancel), .cost(cost), .more(more), .exact(exact), .less(less),
    .paid(paid), .dispense(dispense), .change_out(change_out), .coin_reject(coin_reject),
    .short_funds(short_funds), .busy(busy)
  );

  assign more  = paid > cost;
  assign exact = paid == cost;
  assign less  = paid < cost;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1; coin_value = v; tick(); coin_valid = 1'b0; coin_value = 4'd0;
  endtask

  task automatic buy();
    select = 1'b1; tick(); select = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b1; coin_valid = 0; coin_value = 0; select = 0; cancel = 0; cost = 0;
    #1 reset_L = 1'b0;
    #5;
    checks++;
    if ({paid, dispense, change_out, coin_reject, short_funds, busy} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs: got paid=%0d flags=%b want all zero", paid,
        {dispense, change_out, coin_reject, short_funds, busy});
    end
    @(negedge clock); reset_L = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || paid !== 4'd0) begin
      errors++; $display("FAIL reset_release: got busy=%b paid=%0d want 0 0", busy, paid);
    end
  endtask

  task automatic test_exact();
    int pulses = 0;
    cost = 4'd10;
    coin(4'd5);
    checks++; if (paid !== 4'd5) begin errors++; $display("FAIL exact_paid5: got %0d want 5", paid); end
    coin(4'd5);
    checks++; if (paid !== 4'd10) begin errors++; $display("FAIL exact_paid10: got %0d want 10", paid); end
    checks++; if (exact !== 1'b1) begin errors++; $display("FAIL exact_cmp: got %b want 1", exact); end
    buy();
    checks++;
    if (dispense !== 1'b1 || paid !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL exact_dispense: got disp=%b paid=%0d busy=%b want 1 0 1", dispense, paid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (change_out === 1'b1 || dispense === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL exact_after: got extra_pulses=%0d busy=%b want 0 0", pulses, busy);
    end
  endtask

  task automatic test_change();
    cost = 4'd9;
    coin(4'd7); coin(4'd6);
    checks++; if (paid !== 4'd13) begin errors++; $display("FAIL change_paid: got %0d want 13", paid); end
    buy();
    checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL change_dispense: got %b want 1", dispense); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (change_out !== 1'b1 || busy !== 1'b1 || dispense !== 1'b0) begin
        errors++; $display("FAIL change_pulse%0d: got chg=%b busy=%b disp=%b want 1 1 0", i, change_out, busy, dispense);
      end
    end
    tick();
    checks++;
    if (change_out !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL change_end: got chg=%b busy=%b want 0 0", change_out, busy);
    end
  endtask

  task automatic test_overflow();
    coin(4'd12);
    checks++; if (paid !== 4'd12) begin errors++; $display("FAIL ovf_paid12: got %0d want 12", paid); end
    coin(4'd5);
    checks++;
    if (coin_reject !== 1'b1 || paid !== 4'd12) begin
      errors++; $display("FAIL ovf_reject: got rej=%b paid=%0d want 1 12", coin_reject, paid);
    end
    coin(4'd3);
    checks++;
    if (coin_reject !== 1'b0 || paid !== 4'd15) begin
      errors++; $display("FAIL ovf_fill: got rej=%b paid=%0d want 0 15", coin_reject, paid);
    end
    cost = 4'd15; buy(); tick(); tick();
    checks++; if (paid !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL ovf_clear: got paid=%0d busy=%b want 0 0", paid, busy); end
  endtask

  task automatic test_short();
    cost = 4'd8;
    coin(4'd3);
    buy();
    checks++;
    if (short_funds !== 1'b1 || paid !== 4'd3 || dispense !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL short_pulse: got sf=%b paid=%0d disp=%b busy=%b want 1 3 0 0", short_funds, paid, dispense, busy);
    end
    tick();
    checks++; if (short_funds !== 1'b0) begin errors++; $display("FAIL short_once: got %b want 0", short_funds); end
    cost = 4'd3; buy(); tick(); tick();
  endtask

  task automatic test_coin_in_change();
    int pulses = 0;
    cost = 4'd2;
    coin(4'd5);
    buy(); tick();
    if (change_out === 1'b1) pulses++;
    coin_valid = 1'b1; coin_value = 4'd4; tick(); coin_valid = 1'b0; coin_value = 4'd0;
    if (change_out === 1'b1) pulses++;
    checks++;
    if (coin_reject !== 1'b1 || paid !== 4'd0) begin
      errors++; $display("FAIL busy_coin_reject: got rej=%b paid=%0d want 1 0", coin_reject, paid);
    end
    for (int i = 0; i < 5; i++) begin tick(); if (change_out === 1'b1) pulses++; end
    checks++;
    if (pulses != 3 || busy !== 1'b0 || paid !== 4'd0) begin
      errors++; $display("FAIL busy_coin_refund: got pulses=%0d busy=%b paid=%0d want 3 0 0", pulses, busy, paid);
    end
  endtask

  task automatic test_cancel();
    int pulses = 0;
`ifdef VEND_CANCEL_EN
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || change_out !== 1'b0) begin
      errors++; $display("FAIL cancel_empty: got busy=%b chg=%b want 0 0", busy, change_out);
    end
    coin(4'd6);
    cancel = 1'b1; coin_valid = 1'b1; coin_value = 4'd2; tick();
    cancel = 1'b0; coin_valid = 1'b0; coin_value = 4'd0;
    if (change_out === 1'b1) pulses++;
    checks++;
    if (coin_reject !== 1'b1 || paid !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL cancel_coin: got rej=%b paid=%0d busy=%b want 1 0 1", coin_reject, paid, busy);
    end
    for (int i = 0; i < 8; i++) begin tick(); if (change_out === 1'b1) pulses++; end
    checks++;
    if (pulses != 6 || busy !== 1'b0) begin
      errors++; $display("FAIL cancel_refund: got pulses=%0d busy=%b want 6 0", pulses, busy);
    end
`else
    coin(4'd6);
    cancel = 1'b1; tick();
    checks++;
    if (paid !== 4'd6 || busy !== 1'b0 || change_out !== 1'b0) begin
      errors++; $display("FAIL cancel_ignored: got paid=%0d busy=%b chg=%b want 6 0 0", paid, busy, change_out);
    end
    coin_valid = 1'b1; coin_value = 4'd2; tick();
    cancel = 1'b0; coin_valid = 1'b0; coin_value = 4'd0;
    checks++;
    if (paid !== 4'd8 || coin_reject !== 1'b0) begin
      errors++; $display("FAIL cancel_coin_ok: got paid=%0d rej=%b want 8 0", paid, coin_reject);
    end
    for (int i = 0; i < 3; i++) begin tick(); if (change_out === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL cancel_no_refund: got %0d want 0", pulses); end
    cost = 4'd8; buy(); tick(); tick();
`endif
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    cost = 4'd1;
    coin(4'd5);
    buy(); tick(); tick();
    checks++;
    if (change_out !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: got chg=%b busy=%b want 1 1", change_out, busy);
    end
    reset_L = 1'b0;
    #1;
    checks++;
    if ({paid, dispense, change_out, coin_reject, short_funds, busy} !== 9'd0) begin
      errors++; $display("FAIL rst_mid_async: got paid=%0d flags=%b want all zero", paid,
        {dispense, change_out, coin_reject, short_funds, busy});
    end
    tick();
    @(negedge clock); reset_L = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); if (change_out === 1'b1 || busy === 1'b1) pulses++; end
    checks++;
    if (pulses != 0 || paid !== 4'd0) begin
      errors++; $display("FAIL rst_mid_after: got activity=%0d paid=%0d want 0 0", pulses, paid);
    end
    coin(4'd2);
    checks++; if (paid !== 4'd2) begin errors++; $display("FAIL rst_mid_alive: got %0d want 2", paid); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_exact();
    test_change();
    test_overflow();
    test_short();
    test_coin_in_change();
    test_cancel();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
